// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle restoring divider sequencer for MIPS DIV/DIVU
//
// Purpose: accepts a divide request from the EX stage, latches the operands and
// runs one restoring-division iteration per cycle. It stalls the pipeline while
// busy and pulses result_valid_o for the HI/LO write.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start_i, signed_i    divide request (sampled in IDLE), 1 = DIV, 0 = DIVU
//   dividend_i/divisor_i rs / rt operands, latched at accept
//   cancel_i             flush/exception, aborts an operation in flight
//   stall_o              pipeline stall request (combinational)
//   busy_o               high whenever the sequencer is not idle
//   result_valid_o       one-cycle pulse, hi_o/lo_o valid (HI/LO write enable)
//   hi_o / lo_o          remainder / quotient, held until the next result

module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             cancel_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             result_valid_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    count;
   logic             neg_q;
   logic             neg_r;

   logic             accept;
   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   assign accept  = (state == IDLE) && start_i && !cancel_i;
   assign dvd_neg = signed_i && dividend_i[WIDTH-1];
   assign dvs_neg = signed_i && divisor_i[WIDTH-1];
   // Negating the most negative value wraps to itself, which is still the
   // correct magnitude when read as unsigned.
   assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
   assign dvs_mag = dvs_neg ? -divisor_i : divisor_i;

   // One restoring step: shift {rem,quo} left by one, then trial-subtract.
   // The extra top bit of trial is the borrow (trial negative).
   assign trial   = {rem, quo[WIDTH-1]} - {2'b00, dvsr};
   assign rem_nxt = trial[WIDTH+1] ? {rem[WIDTH-1:0], quo[WIDTH-1]} : trial[WIDTH:0];
   assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH+1]};

   assign stall_o = accept || (state == RUN) || (state == ZERO);
   assign busy_o  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rem            <= '0;
         quo            <= '0;
         dvsr           <= '0;
         count          <= '0;
         neg_q          <= 1'b0;
         neg_r          <= 1'b0;
         result_valid_o <= 1'b0;
         hi_o           <= '0;
         lo_o           <= '0;
      end else begin
         result_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  count <= '0;
                  dvsr  <= dvs_mag;
                  if (divisor_i == '0) begin
                     // Divide by zero: fixed result, raw dividend, no sign fix.
                     quo   <= '1;
                     rem   <= {1'b0, dividend_i};
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= ZERO;
                  end else begin
                     quo   <= dvd_mag;
                     rem   <= '0;
                     neg_q <= dvd_neg ^ dvs_neg;
                     neg_r <= dvd_neg;
                     state <= RUN;
                  end
               end
            end
            ZERO: begin
               if (cancel_i) begin
                  state <= IDLE;
               end else begin
                  state          <= DONE;
                  result_valid_o <= 1'b1;
                  hi_o           <= rem[WIDTH-1:0];
                  lo_o           <= quo;
               end
            end
            RUN: begin
               if (cancel_i) begin
                  state <= IDLE;
               end else begin
                  rem   <= rem_nxt;
                  quo   <= quo_nxt;
                  count <= count + 1'b1;
                  // Results are registered from the final iteration's next
                  // values so they are already valid during DONE.
                  if (count == LAST) begin
                     state          <= DONE;
                     result_valid_o <= 1'b1;
                     lo_o           <= neg_q ? -quo_nxt : quo_nxt;
                     hi_o           <= neg_r ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl

module tb_div_ctrl;

   localparam int W = 32;
   localparam int LAT_RUN = W + 1;
   localparam int LAT_ZERO = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sgn;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         cancel;
   logic         stall;
   logic         busy;
   logic         valid;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   div_ctrl #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start),
      .signed_i       (sgn),
      .dividend_i     (dividend),
      .divisor_i      (divisor),
      .cancel_i       (cancel),
      .stall_o        (stall),
      .busy_o         (busy),
      .result_valid_o (valid),
      .hi_o           (hi),
      .lo_o           (lo)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           s;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: MIPS semantics from plain arithmetic (truncating division).
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa;
      longint sb;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Called in the accept cycle T; walks to the expected DONE cycle T+lat.
   task automatic wait_result(input int lat, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                              input bit keep_start, input string name);
      for (int c = 1; c <= lat; c++) begin
         tick();
         if (c == 1 && !keep_start) begin
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
            sgn      = 1'($urandom);
         end
         #1;
         if (c < lat) begin
            chk({name, " busy valid/stall"}, {62'd0, valid, stall}, 64'b01);
         end else begin
            chk({name, " valid"}, 64'(valid), 64'd1);
            chk({name, " lo"}, 64'(lo), 64'(elo));
            chk({name, " hi"}, 64'(hi), 64'(ehi));
            chk({name, " stall in done"}, 64'(stall), 64'd0);
         end
      end
   endtask

   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input logic [W-1:0] q, input logic [W-1:0] r, input string name);
      dividend = a;
      divisor  = b;
      sgn      = s;
      start    = 1'b1;
      #1;
      chk({name, " stall at accept"}, 64'(stall), 64'd1);
      wait_result((b == '0) ? LAT_ZERO : LAT_RUN, q, r, 1'b0, name);
      tick();
      chk({name, " idle after"}, {62'd0, busy, valid}, 64'd0);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rq;
      logic [W-1:0] rr;
      bit           rs;
      bit           seen;

      vecs[0] = '{32'd100,       32'd7,          1'b0, 32'd14,         32'd2};
      vecs[1] = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
      vecs[2] = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
      vecs[3] = '{32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,   32'd5};
      vecs[4] = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
      vecs[5] = '{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,   32'd0};
      vecs[6] = '{32'hFFFFFFF9,  32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9};

      rst = 1'b1; start = 1'b0; sgn = 1'b0; cancel = 1'b0;
      dividend = '0; divisor = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("reset outputs", {busy, valid, stall, hi, lo}, 67'd0);

      for (int i = 0; i < 7; i++)
         do_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));

      // Cancel mid-run, then restart at T+12.
      do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "pre-cancel");
      dividend = 32'd1000; divisor = 32'd3; sgn = 1'b0; start = 1'b1;
      seen = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (c == 10) cancel = 1'b1;
         if (c == 11) cancel = 1'b0;
         #1;
         if (valid) seen = 1'b1;
      end
      chk("cancel no pulse", 64'(seen), 64'd0);
      chk("cancel idle", {62'd0, busy, stall}, 64'd0);
      chk("cancel hi/lo kept", {hi, lo}, {32'd2, 32'd14});
      tick();
      do_div(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, "restart");

      // Reset in the middle of a run.
      dividend = 32'd100; divisor = 32'd7; sgn = 1'b0; start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) start = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid reset outputs", {busy, valid, stall, hi, lo}, 67'd0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (valid) seen = 1'b1;
      end
      chk("mid reset no pulse", 64'(seen), 64'd0);

      // Back-to-back with start held through DONE.
      dividend = 32'd100; divisor = 32'd7; sgn = 1'b0; start = 1'b1;
      wait_result(LAT_RUN, 32'd14, 32'd2, 1'b1, "b2b first");
      tick();
      dividend = 32'd20; divisor = 32'd3;
      #1;
      chk("b2b idle accept", {62'd0, busy, stall}, 64'b01);
      wait_result(LAT_RUN, 32'd6, 32'd2, 1'b0, "b2b second");
      tick();

      // Start with cancel in IDLE is not accepted.
      start = 1'b1; cancel = 1'b1;
      #1;
      chk("start+cancel stall", 64'(stall), 64'd0);
      tick();
      start = 1'b0; cancel = 1'b0;
      #1;
      chk("start+cancel busy", 64'(busy), 64'd0);

      // Randomized operands against the arithmetic reference.
      for (int i = 0; i < 30; i++) begin
         rs = 1'($urandom);
         case ($urandom_range(0, 4))
            0: ra = 32'h80000000;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: rb = '0;
            1: rb = $urandom_range(1, 15);
            2: rb = 32'hFFFFFFFF - $urandom_range(0, 15);
            default: rb = $urandom;
         endcase
         ref_div(ra, rb, rs, rq, rr);
         do_div(ra, rb, rs, rq, rr, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
